// File: rtl/cpu_multiciclo_pkg.sv
// Shared definitions for the multicycle CPU: opcode/funct encodings,
// FSM state encoding and ULA control codes.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ULA_AND = 3'b000,
    ULA_OR  = 3'b001,
    ULA_ADD = 3'b010,
    ULA_SUB = 3'b110,
    ULA_SLT = 3'b111
  } ula_ctrl_e;

  function automatic ula_ctrl_e funct_to_ula(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ULA_SUB;
      FN_AND:  return ULA_AND;
      FN_OR:   return ULA_OR;
      FN_SLT:  return ULA_SLT;
      default: return ULA_ADD;
    endcase
  endfunction

  // True for every opcode/funct pair the datapath can execute (HALT excluded).
  function automatic logic op_legal(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      OP_RTYPE: return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_multiciclo_regfile.sv
// Parametrised register file: two read ports, one debug read port, one
// write port; R0 always reads zero and ignores writes.
module regfile_param
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic [REG_AW-1:0] ra_dbg,
  output logic [DATA_W-1:0] rd_dbg
);

  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    // NOTE: copy the whole array first so every path assigns regs_d; no latch.
    regs_d = regs_q;
    if (we && (wa != '0)) regs_d[wa] = wd;
  end

  // NOTE: non-blocking assignments keep every flop update in this edge consistent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is small and must read zero after reset, so it is cleared here.
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd1    = (ra1    == '0) ? '0 : regs_q[ra1];
  assign rd2    = (ra2    == '0) ? '0 : regs_q[ra2];
  assign rd_dbg = (ra_dbg == '0) ? '0 : regs_q[ra_dbg];

endmodule

// File: rtl/cpu_multiciclo.sv
// Multicycle CPU: one shared ULA driven by an FSM that runs each instruction
// over 3-5 clocks; step_en gates every state transition.
module cpu_multiciclo
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_data,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [REG_AW-1:0] dbg_ra,
  output logic [DATA_W-1:0] dbg_rd,
  output logic [PC_W-1:0]   pc,
  output logic [2:0]        state,
  output logic              zero,
  output logic              halted,
  output logic              illegal
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
  logic              zero_q, zero_d, illegal_q, illegal_d;

  logic [5:0]        op, funct;
  logic [REG_AW-1:0] rs_a, rt_a, rd_a;
  logic [31:0]       imm_ext;
  logic [DATA_W-1:0] imm;

  logic              rf_we;
  logic [REG_AW-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd, rf_rd1, rf_rd2;

  ula_ctrl_e         ula_ctrl;
  logic [DATA_W-1:0] ula_b, ula_y;

  logic              unused_bits;

  assign op      = ir_q[31:26];
  assign funct   = ir_q[5:0];
  assign rs_a    = ir_q[21 +: REG_AW];
  assign rt_a    = ir_q[16 +: REG_AW];
  assign rd_a    = ir_q[11 +: REG_AW];
  assign imm_ext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imm     = imm_ext[DATA_W-1:0];

  // Field bits that some parameterisations leave unread.
  assign unused_bits = ^{ir_q, imm_ext};

  regfile_param #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .wa     (rf_wa),
    .wd     (rf_wd),
    .ra1    (rs_a),
    .rd1    (rf_rd1),
    .ra2    (rt_a),
    .rd2    (rf_rd2),
    .ra_dbg (dbg_ra),
    .rd_dbg (dbg_rd)
  );

  // ULA: operand B is the immediate for addi/lw/sw; beq compares via subtract.
  always_comb begin
    ula_b    = b_q;
    ula_ctrl = ULA_ADD;
    case (op)
      OP_RTYPE:              ula_ctrl = funct_to_ula(funct);
      OP_ADDI, OP_LW, OP_SW: ula_b    = imm;
      OP_BEQ:                ula_ctrl = ULA_SUB;
      default:               ;
    endcase
    case (ula_ctrl)
      ULA_AND: ula_y = a_q & ula_b;
      ULA_OR:  ula_y = a_q | ula_b;
      ULA_SUB: ula_y = a_q - ula_b;
      ULA_SLT: ula_y = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(ula_b))};
      default: ula_y = a_q + ula_b;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    rf_wa     = rt_a;
    rf_wd     = alu_out_q;
    if (step_en) begin
      case (state_q)
        S_FETCH: begin
          ir_d    = imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
        S_DECODE: begin
          a_d = rf_rd1;
          b_d = rf_rd2;
          if (op == OP_HALT) begin
            state_d = S_HALT;
          end else if (!op_legal(op, funct)) begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_out_d = ula_y;
          zero_d    = (ula_y == '0);
          case (op)
            OP_BEQ: begin
              // pc already points past the beq, so the offset is relative to pc+1.
              if (a_q == b_q) pc_d = pc_q + imm_ext[PC_W-1:0];
              state_d = S_FETCH;
            end
            OP_J: begin
              pc_d    = ir_q[PC_W-1:0];
              state_d = S_FETCH;
            end
            OP_LW, OP_SW: state_d = S_MEM;
            default:      state_d = S_WB;
          endcase
        end
        S_MEM: begin
          if (op == OP_LW) begin
            mdr_d   = dmem_rdata;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_WB: begin
          rf_we   = 1'b1;
          rf_wa   = (op == OP_RTYPE) ? rd_a : rt_a;
          rf_wd   = (op == OP_LW) ? mdr_q : alu_out_q;
          state_d = S_FETCH;
        end
        S_HALT:  ;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  // The write strobe depends on step_en directly so a stalled MEM never writes.
  assign dmem_we    = step_en && (state_q == S_MEM) && (op == OP_SW);
  assign dmem_addr  = alu_out_q;
  assign dmem_wdata = b_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign state      = state_q;
  assign zero       = zero_q;
  assign halted     = (state_q == S_HALT);
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_cpu_multiciclo.sv
// Self-checking bench for cpu_multiciclo: directed programs plus a random
// program, all checked against an instruction-level reference model.
module tb_cpu_multiciclo;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int PW    = 8;
  localparam int NREG  = 8;
  localparam int DMASK = 255;
  localparam int PMASK = 255;

  localparam int K_ALU  = 0;
  localparam int K_LW   = 1;
  localparam int K_SW   = 2;
  localparam int K_BR   = 3;
  localparam int K_HALT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          step_en = 1'b1;
  logic [PW-1:0] imem_addr, pc;
  logic [31:0]   imem_data;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata, dbg_rd;
  logic          dmem_we, zero, halted, illegal;
  logic [AW-1:0] dbg_ra = '0;
  logic [2:0]    state;

  logic [31:0]   rom [256];
  logic [DW-1:0] ram [256];

  always #10 clk = ~clk;

  assign imem_data  = rom[imem_addr];
  assign dmem_rdata = ram[dmem_addr];
  always @(posedge clk) if (dmem_we) ram[dmem_addr] <= dmem_wdata;

  cpu_multiciclo #(.DATA_W(DW), .REG_AW(AW), .PC_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_en    (step_en),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata),
    .dbg_ra     (dbg_ra),
    .dbg_rd     (dbg_rd),
    .pc         (pc),
    .state      (state),
    .zero       (zero),
    .halted     (halted),
    .illegal    (illegal)
  );

  int n_chk = 0;
  int n_err = 0;

  // Architectural reference model.
  logic [DW-1:0] m_reg [NREG];
  logic [DW-1:0] m_mem [256];
  logic [PW-1:0] m_pc;
  bit            m_zero, m_zero_known, m_halted, m_illegal;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int target);
    return {6'h02, 26'(target)};
  endfunction

  function automatic int sx(input int v);
    return (v >= (1 << (DW - 1))) ? v - (1 << DW) : v;
  endfunction

  function automatic void m_wr(input int idx, input int v);
    if (idx != 0) m_reg[idx] = DW'(v & DMASK);
  endfunction

  function automatic int latency(input int kind);
    case (kind)
      K_ALU, K_SW: return 4;
      K_LW:        return 5;
      default:     return 3;
    endcase
  endfunction

  // FSM state expected at the idx-th clock of an instruction of this kind.
  function automatic int exp_state(input int kind, input int idx);
    if (idx < 2) return idx;
    if (idx == 2) return (kind == K_HALT) ? 5 : 2;
    if (idx == 3) return (kind == K_ALU) ? 4 : 3;
    return 4;
  endfunction

  task automatic model_step(input logic [31:0] ins, output int kind, output int sw_addr, output int sw_data);
    int op, fn, rs, rt, rd, a, b, imm, r, addr;
    bit legal;
    op  = int'(ins[31:26]);
    fn  = int'(ins[5:0]);
    rs  = int'(ins[25:21]) % NREG;
    rt  = int'(ins[20:16]) % NREG;
    rd  = int'(ins[15:11]) % NREG;
    a   = int'(m_reg[rs]);
    b   = int'(m_reg[rt]);
    imm = int'($signed(ins[15:0]));
    r   = 0;
    sw_addr = 0;
    sw_data = 0;
    m_pc = PW'((int'(m_pc) + 1) & PMASK);
    case (op)
      'h00: begin
        legal = 1'b1;
        case (fn)
          'h20: r = a + b;
          'h22: r = a - b;
          'h24: r = a & b;
          'h25: r = a | b;
          'h2a: r = (sx(a) < sx(b)) ? 1 : 0;
          default: legal = 1'b0;
        endcase
        if (legal) begin
          m_wr(rd, r);
          m_zero = ((r & DMASK) == 0);
          m_zero_known = 1'b1;
          kind = K_ALU;
        end else begin
          m_illegal = 1'b1;
          m_halted  = 1'b1;
          kind = K_HALT;
        end
      end
      'h08: begin
        r = a + imm;
        m_wr(rt, r);
        m_zero = ((r & DMASK) == 0);
        m_zero_known = 1'b1;
        kind = K_ALU;
      end
      'h23: begin
        addr = (a + imm) & DMASK;
        m_zero = (addr == 0);
        m_zero_known = 1'b1;
        m_wr(rt, int'(m_mem[addr]));
        kind = K_LW;
      end
      'h2b: begin
        addr = (a + imm) & DMASK;
        m_zero = (addr == 0);
        m_zero_known = 1'b1;
        m_mem[addr] = DW'(b);
        sw_addr = addr;
        sw_data = b;
        kind = K_SW;
      end
      'h04: begin
        m_zero = (a == b);
        m_zero_known = 1'b1;
        if (a == b) m_pc = PW'((int'(m_pc) + imm) & PMASK);
        kind = K_BR;
      end
      'h02: begin
        m_pc = ins[PW-1:0];
        m_zero_known = 1'b0;
        kind = K_BR;
      end
      'h3f: begin
        m_halted = 1'b1;
        kind = K_HALT;
      end
      default: begin
        m_illegal = 1'b1;
        m_halted  = 1'b1;
        kind = K_HALT;
      end
    endcase
  endtask

  task automatic check_reg(input int r, input logic [DW-1:0] exp, input string tag);
    dbg_ra = AW'(r);
    #1;
    check(tag, 32'(dbg_rd), 32'(exp));
  endtask

  task automatic check_arch();
    check("pc", 32'(pc), 32'(m_pc));
    check("imem_addr", 32'(imem_addr), 32'(m_pc));
    check("halted", 32'(halted), 32'(m_halted));
    check("illegal", 32'(illegal), 32'(m_illegal));
    if (m_zero_known) check("zero", 32'(zero), 32'(m_zero));
    for (int r = 0; r < NREG; r++) check_reg(r, m_reg[r], $sformatf("R%0d", r));
  endtask

  // Runs the instruction at the model pc; step_en is high one cycle in every `gate`.
  task automatic run_instr(input int gate);
    logic [31:0] ins;
    int kind, lat, idx, cyc, sw_addr, sw_data;
    bit exp_we;
    ins = rom[m_pc];
    model_step(ins, kind, sw_addr, sw_data);
    lat = latency(kind);
    idx = 0;
    cyc = 0;
    while (idx < lat) begin
      step_en = ((cyc % gate) == 0);
      #1;
      check("state", 32'(state), 32'(exp_state(kind, idx)));
      exp_we = step_en && (kind == K_SW) && (idx == 3);
      check("dmem_we", 32'(dmem_we), 32'(exp_we));
      if (exp_we) begin
        check("dmem_addr", 32'(dmem_addr), 32'(sw_addr));
        check("dmem_wdata", 32'(dmem_wdata), 32'(sw_data));
      end
      @(posedge clk);
      #1;
      if (step_en) idx++;
      cyc++;
    end
    step_en = 1'b1;
    check_arch();
    if (kind == K_SW) check("ram_after_sw", 32'(ram[sw_addr]), 32'(m_mem[sw_addr]));
  endtask

  task automatic idle_halted(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check("halt_state", 32'(state), 32'd5);
      check("halt_pc", 32'(pc), 32'(m_pc));
      check("halt_we", 32'(dmem_we), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    step_en = 1'b1;
    #1;
    for (int r = 0; r < NREG; r++) m_reg[r] = '0;
    m_pc = '0;
    m_zero = 1'b0;
    m_zero_known = 1'b1;
    m_halted = 1'b0;
    m_illegal = 1'b0;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    for (int r = 0; r < NREG; r++) check_reg(r, '0, $sformatf("rst_R%0d", r));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    int k, rs, rt, rd, imm;
    k   = $urandom_range(0, 9);
    rs  = $urandom_range(0, 31);
    rt  = $urandom_range(0, 31);
    rd  = $urandom_range(0, 31);
    imm = $urandom_range(0, 65535);
    case (k)
      0: return enc_r(rs, rt, rd, 6'h20);
      1: return enc_r(rs, rt, rd, 6'h22);
      2: return enc_r(rs, rt, rd, 6'h24);
      3: return enc_r(rs, rt, rd, 6'h25);
      4: return enc_r(rs, rt, rd, 6'h2a);
      5: return enc_i(6'h08, rs, rt, imm);
      6: return enc_i(6'h23, rs, rt, imm);
      7: return enc_i(6'h2b, rs, rt, imm);
      8: return enc_i(6'h04, rs, rt, imm);
      default: return enc_j($urandom_range(0, 1023));
    endcase
  endfunction

  task automatic fill_rom_halt();
    for (int i = 0; i < 256; i++) rom[i] = 32'hFC00_0000;
  endtask

  initial begin
    fill_rom_halt();
    for (int i = 0; i < 256; i++) begin
      ram[i]   = DW'($urandom);
      m_mem[i] = ram[i];
    end

    // Arithmetic, memory and branch sequence.
    rom[0] = enc_i(6'h08, 0, 1, 5);
    rom[1] = enc_i(6'h08, 0, 2, 3);
    rom[2] = enc_r(1, 2, 3, 6'h20);
    rom[3] = enc_r(2, 1, 4, 6'h22);
    rom[4] = enc_r(4, 1, 5, 6'h2a);
    rom[5] = enc_i(6'h2b, 0, 1, 4);
    rom[6] = enc_i(6'h23, 0, 6, 4);
    rom[7] = enc_i(6'h04, 1, 1, -1);
    do_reset();
    repeat (3) run_instr(1);
    check("pc_after_12clk", 32'(pc), 32'd3);
    check_reg(3, 8'd8, "R3_add");
    run_instr(1);
    check_reg(4, 8'hFE, "R4_sub");
    run_instr(1);
    check_reg(5, 8'd1, "R5_slt");
    check("zero_after_slt", 32'(zero), 32'd0);
    run_instr(1);
    check("ram4_after_sw", 32'(ram[4]), 32'd5);
    run_instr(4);
    check_reg(6, 8'd5, "R6_lw_gated");
    repeat (3) begin
      run_instr(1);
      check("beq_loop_pc", 32'(pc), 32'd7);
    end

    // Jump, untaken branch, halt.
    fill_rom_halt();
    rom[0]  = enc_j(32'h20);
    rom[32] = enc_i(6'h08, 0, 2, 7);
    rom[33] = enc_i(6'h04, 2, 0, 3);
    do_reset();
    run_instr(1);
    check("j_pc", 32'(pc), 32'h20);
    repeat (3) run_instr(1);
    idle_halted(4);

    // Reset asserted while a store sits in MEM.
    fill_rom_halt();
    rom[0]   = enc_i(6'h08, 0, 1, 8'h5A);
    rom[1]   = enc_i(6'h2b, 0, 1, 9);
    ram[9]   = 8'h11;
    m_mem[9] = 8'h11;
    do_reset();
    run_instr(1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("sw_in_mem_state", 32'(state), 32'd3);
    check("sw_in_mem_we", 32'(dmem_we), 32'd1);
    do_reset();
    check("ram9_after_reset", 32'(ram[9]), 32'h11);

    // Undecoded opcode.
    fill_rom_halt();
    rom[0] = {6'h15, 26'h0};
    do_reset();
    run_instr(1);
    check("illegal_flag", 32'(illegal), 32'd1);
    idle_halted(4);

    // Random program with random step gating.
    for (int i = 0; i < 256; i++) rom[i] = rand_instr();
    do_reset();
    repeat (80) run_instr($urandom_range(1, 3));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_multiciclo.md
Name: cpu_multiciclo

Overview:
- Parametrised multicycle successor to the single-cycle 8-bit datapath (RegisterFile/ULA/Unidade_Controle/Registrador_PC/ROM).
- One shared ULA and an FSM controller run each instruction over 3–5 clocks.
- Adds data-memory access (lw/sw), branches (beq), jumps (j), halt and single-step gating.
- Sits between an external instruction ROM (combinational read) and an external data RAM (combinational read, synchronous write) inside the board top level.

Parameters:
- DATA_W, 8: datapath and register width in bits (8..32).
- REG_AW, 3: register-file address width; 2**REG_AW registers.
- PC_W, 8: program counter width; word-addressed instruction index.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- step_en  in  1  FSM advances one state per clk only while 1; tie to 1 for free-run.
- imem_addr  out  PC_W  instruction address, equals pc.
- imem_data  in  32  instruction word from ROM.
- dmem_addr  out  DATA_W  data address, equals ULA result register.
- dmem_wdata  out  DATA_W  store data (rt value).
- dmem_we  out  1  write strobe, high for exactly one MEM cycle of sw.
- dmem_rdata  in  DATA_W  load data, combinational.
- dbg_ra  in  REG_AW  debug register select.
- dbg_rd  out  DATA_W  debug register value, combinational.
- pc  out  PC_W  current program counter.
- state  out  3  FSM state code.
- zero  out  1  ULA zero flag of last EXEC.
- halted  out  1  high in HALT state.
- illegal  out  1  sticky; set on an undecoded opcode/funct.

Behaviour:
- Reset (async, rst_n=0):
  - pc=0, state=FETCH, IR=0, A/B/ALUOut/MDR=0, all registers=0.
  - dmem_we=0, zero=0, halted=0, illegal=0.
  - Reset dominates step_en and any in-flight instruction; a partial sw never writes after reset.
- step_en=0: every register holds, dmem_we forced 0. step_en=1: one transition per rising edge.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH: IR<=imem_data; pc<=pc+1 (wraps 2**PC_W-1 -> 0); next DECODE.
- DECODE:
  - A<=R[IR[25:21]], B<=R[IR[20:16]]; register fields are truncated to the low REG_AW bits.
  - Opcode 111111 -> HALT; undecoded opcode/funct -> illegal<=1, HALT; otherwise EXEC.
- EXEC:
  - R-type (op 000000): ALUOut<=A op B. Funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed) -> WB.
  - addi (001000): ALUOut<=A+imm -> WB.
  - lw (100011) / sw (101011): ALUOut<=A+imm -> MEM.
  - beq (000100): if A==B then pc<=pc+imm[PC_W-1:0] (pc already incremented) -> FETCH.
  - j (000010): pc<=IR[PC_W-1:0] -> FETCH.
  - zero<=(A op B)==0, updated in every EXEC.
- MEM:
  - lw: MDR<=dmem_rdata -> WB.
  - sw: dmem_we=1 for this cycle, dmem_addr=ALUOut, dmem_wdata=B -> FETCH.
- WB:
  - R-type: R[IR[15:11]]<=ALUOut.
  - addi: R[IR[20:16]]<=ALUOut.
  - lw: R[IR[20:16]]<=MDR.
  - Next FETCH.
- imm: IR[15:0] sign-extended to max(16,DATA_W), then truncated to DATA_W.
- Arithmetic is modulo 2**DATA_W; no overflow trap.
- R0 reads as 0; writes to R0 are discarded.
- Latency (clocks at step_en=1): beq/j 3, R-type/addi/sw 4, lw 5.
- HALT is absorbing until reset; pc frozen, no register or memory writes.
- Debug port reads the register array directly and reflects a WB write from the cycle after the write edge.

Decomposition:
- Package cpu_pkg:
  - opcode and funct constants.
  - state encoding (3-bit enum).
  - ULA control codes: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- Sub-module regfile_param (DATA_W, REG_AW):
  - two read ports plus a debug read port, one write port, async active-low clear, R0 hardwired zero.
- ULA decode and FSM stay in the top.

Test Plan:
- addi R1,R0,5; addi R2,R0,3; add R3,R1,R2 -> R3=8 via dbg, pc=3 after 12 clks; state cycles 0,1,2,4.
- sub R4,R2,R1 -> R4=0xFE (DATA_W=8); slt R5,R4,R1 -> R5=1 (signed -2<5); zero=0.
- sw R1,4(R0) then lw R6,4(R0) against a model RAM -> dmem_we high exactly 1 clk with addr=4, wdata=5; R6=5 after 5 clks.
- beq R1,R1,-1 at pc=7 -> pc returns to 7 every 3 clks; j 0x20 -> pc=0x20.
- step_en toggled 1-of-4 cycles during lw -> same final R6, dmem_we never high while step_en=0.
- rst_n pulsed low in MEM of sw -> no write, all outputs at reset values immediately. Opcode 0x15 -> illegal=1, halted=1, pc frozen.
